// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, PC increment and queue entry type for the fetch slice
package fetch_pkg;
   localparam int XLEN  = 32;
   localparam int INS_W = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [INS_W-1:0] ins;
      logic [XLEN-1:0]  pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_if.sv
// rtl/fetch_prefetch_if.sv - decode/execute facing handshake of the prefetcher
interface fetch_prefetch_if;
   import fetch_pkg::*;

   logic              ins_ready;
   logic              br_taken;
   logic [XLEN-1:0]   br_target;
   logic              ins_valid;
   logic [INS_W-1:0]  ins;
   logic [XLEN-1:0]   ins_pc;
   logic              trap;

   modport master (input ins_ready, br_taken, br_target,
                   output ins_valid, ins, ins_pc, trap);
   modport slave  (output ins_ready, br_taken, br_target,
                   input ins_valid, ins, ins_pc, trap);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO with flush; DEPTH must be a power of two
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count
);
   fetch_entry_t store [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot the push needs
   assign do_push = push & (~full | do_pop);
   assign head    = store[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~flush) store[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction prefetcher with synchronous memory and redirect
// Optional fetch fault detection enabled by macro FETCH_TRAP_EN.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int              MEM_WORDS   = 256,
   parameter int              QUEUE_DEPTH = 2,
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0
) (
   input  logic clk,
   input  logic reset,
   fetch_prefetch_if.master bus
);
   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [INS_W-1:0] mem [MEM_WORDS];

   logic [XLEN-1:0] pc, issue_addr;
   logic            resp_valid, trap_q;
   fetch_entry_t    resp, head;
   logic            pop, issue, credit_ok, addr_bad;
   logic [29:0]     word;
   logic [AW-1:0]   mem_idx;
   logic [CW:0]     occupancy;
   logic            q_full, q_empty;
   logic [CW-1:0]   q_count;

   assign pop        = ~q_empty & bus.ins_ready;
   // slots that would be taken once this cycle's pop and response settle
   assign occupancy  = {1'b0, q_count} - (CW+1)'(pop) + (CW+1)'(resp_valid);
   assign credit_ok  = ~(q_full & ~pop) & (occupancy < (CW+1)'(QUEUE_DEPTH));
   assign issue_addr = bus.br_taken ? bus.br_target : pc;
   assign word       = issue_addr[XLEN-1:2];
   assign mem_idx    = AW'(word % 30'(MEM_WORDS));
   assign issue      = ~trap_q & (bus.br_taken | credit_ok);

`ifdef FETCH_TRAP_EN
   assign addr_bad = (word >= 30'(MEM_WORDS)) || (issue_addr[1:0] != 2'b00);
   assign bus.trap = trap_q;
`else
   assign addr_bad = 1'b0;
   assign bus.trap = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= RESET_PC;
         resp_valid <= 1'b0;
         resp       <= '0;
         trap_q     <= 1'b0;
      end else begin
         resp_valid <= issue & ~addr_bad;
         if (issue & ~addr_bad) resp <= '{ins: mem[mem_idx], pc: issue_addr};
         if (issue & addr_bad)  trap_q <= 1'b1;
         if (bus.br_taken)      pc <= bus.br_target + PC_INC;
         else if (issue)        pc <= pc + PC_INC;
      end
   end

   // a redirect kills both the queue contents and the response arriving this cycle
   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.br_taken),
      .push      (resp_valid & ~bus.br_taken),
      .push_data (resp),
      .pop       (pop & ~bus.br_taken),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign bus.ins_valid = ~q_empty;
   assign bus.ins       = q_empty ? '0 : head.ins;
   assign bus.ins_pc    = q_empty ? '0 : head.pc;
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   fetch_prefetch_if bus ();

   fetch_prefetch #(.MEM_WORDS(256), .QUEUE_DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step;
      @(negedge clk);
   endtask

   // leaves reset released at a negedge; first ins_valid expected two negedges later
   task automatic do_reset(input logic ready);
      reset         = 1'b1;
      bus.br_taken  = 1'b0;
      bus.br_target = 32'h0;
      bus.ins_ready = ready;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset         = 1'b1;
      bus.ins_ready = 1'b1;
      bus.br_taken  = 1'b0;
      bus.br_target = 32'h0;
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.ins_valid); end
      n_checks++;
      if (bus.ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins got %h exp 0", bus.ins); end
      n_checks++;
      if (bus.ins_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", bus.ins_pc); end
      n_checks++;
      if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %b exp 0", bus.trap); end
   endtask

   task automatic test_stream;
      do_reset(1'b1);
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid got %b exp 0", bus.ins_valid); end
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (bus.ins_valid !== 1'b1 || bus.ins !== 32'hE0000000 + 32'(k) || bus.ins_pc !== 32'(4*k)) begin
            n_fail++;
            $display("FAIL stream_%0d got v=%b ins=%h pc=%h exp v=1 ins=%h pc=%h", k,
                     bus.ins_valid, bus.ins, bus.ins_pc, 32'hE0000000 + 32'(k), 32'(4*k));
         end
      end
   endtask

   task automatic test_stall;
      do_reset(1'b0);
      step();
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++;
         if (bus.ins_valid !== 1'b1 || bus.ins !== 32'hE0000000 || bus.ins_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got v=%b ins=%h pc=%h exp v=1 ins=e0000000 pc=0", k,
                     bus.ins_valid, bus.ins, bus.ins_pc);
         end
      end
      bus.ins_ready = 1'b1;
      for (int k = 1; k < 7; k++) begin
         step();
         n_checks++;
         if (bus.ins_valid !== 1'b1 || bus.ins !== 32'hE0000000 + 32'(k) || bus.ins_pc !== 32'(4*k)) begin
            n_fail++;
            $display("FAIL stall_release_%0d got v=%b ins=%h pc=%h exp ins=%h pc=%h", k,
                     bus.ins_valid, bus.ins, bus.ins_pc, 32'hE0000000 + 32'(k), 32'(4*k));
         end
      end
   endtask

   task automatic test_branch;
      do_reset(1'b1);
      step();
      step();
      step();
      step();
      n_checks++;
      if (bus.ins_pc !== 32'h8) begin n_fail++; $display("FAIL branch_setup got pc=%h exp 8", bus.ins_pc); end
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h40;
      step();
      bus.br_taken = 1'b0;
      n_checks++;
      if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL branch_bubble got v=%b exp 0", bus.ins_valid); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h40 + 32'(4*k) || bus.ins !== 32'hE0000010 + 32'(k)) begin
            n_fail++;
            $display("FAIL branch_target_%0d got v=%b ins=%h pc=%h exp ins=%h pc=%h", k,
                     bus.ins_valid, bus.ins, bus.ins_pc, 32'hE0000010 + 32'(k), 32'h40 + 32'(4*k));
         end
      end
   endtask

   task automatic test_branch_full;
      do_reset(1'b0);
      step();
      step();
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL full_setup got v=%b pc=%h exp v=1 pc=0", bus.ins_valid, bus.ins_pc);
      end
      bus.ins_ready = 1'b1;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h80;
      step();
      bus.br_taken = 1'b0;
      n_checks++;
      if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush got v=%b exp 0", bus.ins_valid); end
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h80 || bus.ins !== 32'hE0000020) begin
         n_fail++;
         $display("FAIL full_target got v=%b ins=%h pc=%h exp ins=e0000020 pc=80", bus.ins_valid, bus.ins, bus.ins_pc);
      end
   endtask

   task automatic test_out_of_range;
      do_reset(1'b1);
      step();
      step();
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h400;
      step();
      bus.br_taken = 1'b0;
`ifdef FETCH_TRAP_EN
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (bus.trap !== 1'b1 || bus.ins_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_%0d got trap=%b v=%b exp trap=1 v=0", k, bus.trap, bus.ins_valid);
         end
         step();
      end
`else
      n_checks++;
      if (bus.ins_valid !== 1'b0 || bus.trap !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_bubble got v=%b trap=%b exp 0 0", bus.ins_valid, bus.trap);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h400 + 32'(4*k) || bus.ins !== 32'hE0000000 + 32'(k)) begin
            n_fail++;
            $display("FAIL wrap_%0d got v=%b ins=%h pc=%h exp ins=%h pc=%h", k,
                     bus.ins_valid, bus.ins, bus.ins_pc, 32'hE0000000 + 32'(k), 32'h400 + 32'(4*k));
         end
      end
`endif
   endtask

   task automatic test_reset_mid;
      do_reset(1'b0);
      step();
      step();
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_setup got v=%b pc=%h exp v=1 pc=0", bus.ins_valid, bus.ins_pc);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_async got v=%b ins=%h exp v=0 ins=0", bus.ins_valid, bus.ins);
      end
      step();
      bus.ins_ready = 1'b1;
      reset = 1'b0;
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_early got v=%b exp 0", bus.ins_valid); end
      step();
      n_checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0 || bus.ins !== 32'hE0000000) begin
         n_fail++;
         $display("FAIL midreset_restart got v=%b ins=%h pc=%h exp ins=e0000000 pc=0", bus.ins_valid, bus.ins, bus.ins_pc);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      for (int i = 0; i < 256; i++) dut.mem[i] = 32'hE0000000 + 32'(i);
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_branch_full();
      test_out_of_range();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter MEM_WORDS, 256, instruction memory depth in 32-bit words.
REQ-002 Parameter QUEUE_DEPTH, 2, prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, 32'h0, byte address fetched first after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ins_ready  in  1  decode accepts head instruction this cycle.
REQ-007 br_taken  in  1  redirect request from execute.
REQ-008 br_target  in  32  byte address of redirect; sampled only when br_taken=1.
REQ-009 ins_valid  out  1  head instruction present.
REQ-010 ins  out  32  head instruction word.
REQ-011 ins_pc  out  32  byte address of head instruction.
REQ-012 trap  out  1  sticky fetch fault.

Function
REQ-013 Instruction storage SHALL be an internal array named mem, MEM_WORDS x 32, loadable by $readmemh; word index = addr[31:2].
REQ-014 Memory read SHALL be synchronous: the address issued in cycle c SHALL yield data and a response-valid flag in cycle c+1.
REQ-015 A fetch SHALL issue in a cycle when (count - pop + resp_valid) < QUEUE_DEPTH, no trap is set, and reset is low; pop = ins_valid & ins_ready.
REQ-016 On each non-redirect issue, the issue address SHALL be pc and pc SHALL advance by 4.
REQ-017 A response present in cycle c SHALL be written to the queue at the end of cycle c, with its pc, unless killed by REQ-019.
REQ-018 ins_valid SHALL equal queue non-empty; ins and ins_pc SHALL come from the head entry, with no bypass from the memory response.
REQ-019 When br_taken=1 in cycle T: queue cleared; response in T discarded; pop ignored; issue address = br_target regardless of REQ-015 credit; pc <= br_target + 4.
REQ-020 The first instruction at br_target SHALL appear with ins_valid=1 in cycle T+2; no pre-redirect instruction SHALL appear after T.
REQ-021 ins_ready=0 with the queue full SHALL hold ins/ins_pc stable and stop issuing, with no instruction lost or duplicated.
REQ-022 Simultaneous push and pop on a full queue SHALL be legal, with count unchanged.
REQ-023 Steady state with ins_ready=1 SHALL deliver one instruction per cycle.

Reset
REQ-024 While reset=1: pc=RESET_PC, queue empty, resp_valid=0, ins_valid=0, ins=0, ins_pc=0, trap=0.
REQ-025 The first issue SHALL occur in the first cycle after reset falls; the first ins_valid SHALL follow two cycles later.
REQ-026 Reset asserted mid-stream SHALL discard queued and in-flight data immediately; mem contents SHALL be preserved.

Configuration
REQ-027 Macro FETCH_TRAP_EN defined: trap SHALL set at the end of any cycle whose issue address has word index >= MEM_WORDS or bits[1:0] != 0; it stays set until reset, issuing stops, and queued entries still drain.
REQ-028 Macro FETCH_TRAP_EN undefined: the word index SHALL wrap modulo MEM_WORDS, bits[1:0] SHALL be ignored, and trap SHALL be tied 0 with the port retained.

Structure
REQ-029 Package fetch_pkg SHALL hold XLEN=32, INS_W=32, the PC increment constant 4, and a typedef for a queue entry {ins, pc}.
REQ-030 The queue SHALL be a sub-module fetch_queue: synchronous FIFO with flush, push, pop, full, empty, and count outputs.

Verification
REQ-031 Load mem[i]=32'hE0000000+i; reset, ins_ready=1 -> ins_valid rises two cycles after reset release; ins/ins_pc = E0000000/0, E0000001/4, E0000002/8, one per cycle.
REQ-032 ins_ready=0 for 6 cycles after the first ins_valid -> ins=E0000000 is held; release -> E0000001, E0000002... follow contiguously, none skipped.
REQ-033 br_taken=1 with br_target=32'h40 when ins_pc=8 -> no ins_valid in T+1; ins_pc=40 and ins=E0000010 in T+2; then 44, 48.
REQ-034 br_taken=1 coinciding with pop on a full queue -> queue flushed; the next delivered ins_pc is br_target.
REQ-035 FETCH_TRAP_EN defined, br_target=32'h400 with MEM_WORDS=256 -> trap=1 one cycle after T and stays high; no further ins_valid. Undefined -> ins=mem[0] is delivered at ins_pc=400.
REQ-036 reset pulse while the queue holds 2 entries -> ins_valid=0 immediately; the fetch restarts at RESET_PC per REQ-025.
